// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, funct codes, encoder request kinds and
// encoder FSM state encodings. Also used by the control decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] KIND_ADD  = 4'd0;
  localparam logic [3:0] KIND_SUB  = 4'd1;
  localparam logic [3:0] KIND_AND  = 4'd2;
  localparam logic [3:0] KIND_OR   = 4'd3;
  localparam logic [3:0] KIND_SLT  = 4'd4;
  localparam logic [3:0] KIND_LW   = 4'd5;
  localparam logic [3:0] KIND_SW   = 4'd6;
  localparam logic [3:0] KIND_BEQ  = 4'd7;
  localparam logic [3:0] KIND_ADDI = 4'd8;
  localparam logic [3:0] KIND_J    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } enc_state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_field_pack.sv
// Combinational packer: instruction kind plus register/immediate/target fields
// to a 32-bit MIPS word, flagging kinds 10-15 as illegal.
module mips_field_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (kind)
      KIND_ADD:  word = r_word(rs, rt, rd, FUNCT_ADD);
      KIND_SUB:  word = r_word(rs, rt, rd, FUNCT_SUB);
      KIND_AND:  word = r_word(rs, rt, rd, FUNCT_AND);
      KIND_OR:   word = r_word(rs, rt, rd, FUNCT_OR);
      KIND_SLT:  word = r_word(rs, rt, rd, FUNCT_SLT);
      KIND_LW:   word = i_word(OP_LW, rs, rt, imm);
      KIND_SW:   word = i_word(OP_SW, rs, rt, imm);
      KIND_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      KIND_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      KIND_J:    word = {OP_J, target};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instruction requests, encodes them and
// streams them into instruction memory at sequential word addresses.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          finish,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err,
  output logic          done
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  enc_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] issued_q, issued_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [31:0] packed_word;
  logic        packed_illegal;
  logic        full_c;
  logic        ready_c;
  logic        accept;
  logic        wr_done;

  mips_field_pack u_pack (
    .kind    (req_kind),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .target  (req_target),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // count only covers completed writes; issued_q also covers the one in flight,
  // so it stops a (DEPTH+1)-th accept while the DEPTH-th write is still pending.
  assign full_c  = (count_q == DEPTH_C);
  assign ready_c = (state_q == ST_RUN) && !full_c && (issued_q != DEPTH_C)
                   && (!we_q || imem_ready);
  assign accept  = req_valid && ready_c;
  assign wr_done = we_q && imem_ready;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    count_d  = count_q;
    issued_d = issued_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (wr_done) begin
      we_d    = 1'b0;
      count_d = count_q + ONE_C;
    end

    if (accept) begin
      if (packed_illegal) begin
        err_d = 1'b1;
      end else begin
        we_d     = 1'b1;
        wdata_d  = packed_word;
        addr_d   = issued_q[AW-1:0];
        issued_d = issued_q + ONE_C;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          count_d  = '0;
          issued_d = '0;
          err_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (finish)                  state_d = ST_DRAIN;
        else if (count_d == DEPTH_C) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (finish) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!we_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      addr_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign req_ready  = ready_c;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_c;
  assign err        = err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder (DEPTH=4 instance).
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, finish;
  logic        req_valid, req_ready;
  logic [3:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        imem_we, imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;
  logic        full, err, done;

  int checks = 0;
  int errors = 0;

  mips_instr_encoder #(.AW(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .req_target (req_target),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    req_valid  = 1'b1;
    req_kind   = k;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_imm    = imm;
    req_target = tgt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({full, err, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {full, err, done}); end
    $display("reset: ready=%b we=%b addr=%h wdata=%h count=%0d", req_ready, imem_we, imem_addr, imem_wdata, count);
  endtask

  task automatic test_add();
    imem_ready = 1'b1;
    pulse_start();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00221820 || imem_addr !== 8'd0) begin
      errors++; $display("FAIL add_write got we=%b %h@%0d want 1 00221820@0", imem_we, imem_wdata, imem_addr); end
    $display("add: wdata=%h addr=%0d", imem_wdata, imem_addr);
    tick();
    checks++; if (count !== 9'd1 || imem_we !== 1'b0) begin errors++; $display("FAIL add_count got %0d we=%b want 1 we=0", count, imem_we); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h8FA80004;
    exp_w[1] = 32'h1022FFFF;
    exp_w[2] = 32'h08000010;
    imem_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        1: set_req(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        default: set_req(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
      endcase
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, req_ready); end
      tick();
      checks++; if (imem_we !== 1'b1 || imem_wdata !== exp_w[i] || imem_addr !== 8'(i)) begin
        errors++; $display("FAIL b2b_write[%0d] got we=%b %h@%0d want 1 %h@%0d", i, imem_we, imem_wdata, imem_addr, exp_w[i], i); end
      $display("b2b[%0d]: wdata=%h addr=%0d", i, imem_wdata, imem_addr);
    end
    req_valid = 1'b0;
    tick();
    checks++; if (count !== 9'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", count); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
  endtask

  task automatic test_stall();
    imem_ready = 1'b0;
    pulse_start();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    set_req(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00221820 || imem_addr !== 8'd0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got we=%b %h@%0d rdy=%b want 1 00221820@0 rdy=0", i, imem_we, imem_wdata, imem_addr, req_ready); end
      $display("stall[%0d]: we=%b wdata=%h ready=%b", i, imem_we, imem_wdata, req_ready);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (imem_wdata !== 32'h00853022 || imem_addr !== 8'd1 || count !== 9'd1) begin
      errors++; $display("FAIL stall_next got %h@%0d cnt=%0d want 00853022@1 cnt=1", imem_wdata, imem_addr, count); end
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
  endtask

  task automatic test_full();
    imem_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      set_req(4'd0, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d] got %b want 1", i, req_ready); end
      tick();
    end
    checks++; if (req_ready !== 1'b0 || count !== 9'd3 || imem_addr !== 8'd3) begin
      errors++; $display("FAIL full_last_pending got rdy=%b cnt=%0d addr=%0d want 0 3 3", req_ready, count, imem_addr); end
    tick();
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || full !== 1'b1 || count !== 9'd4) begin
      errors++; $display("FAIL full_state got rdy=%b full=%b cnt=%0d want 0 1 4", req_ready, full, count); end
    $display("full: count=%0d full=%b ready=%b", count, full, req_ready);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", done); end
  endtask

  task automatic test_illegal();
    imem_ready = 1'b1;
    pulse_start();
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    checks++; if (err !== 1'b1 || imem_we !== 1'b0) begin errors++; $display("FAIL illegal_err got err=%b we=%b want 1 0", err, imem_we); end
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    req_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00221820) begin
      errors++; $display("FAIL illegal_next got we=%b %h@%0d want 1 00221820@0", imem_we, imem_wdata, imem_addr); end
    $display("illegal: err=%b next wdata=%h addr=%0d", err, imem_wdata, imem_addr);
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b want 1", err); end
    pulse_start();
    checks++; if (err !== 1'b0 || count !== 9'd0) begin errors++; $display("FAIL illegal_clear got err=%b cnt=%0d want 0 0", err, count); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    pulse_start();
    set_req(4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    tick();
    req_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b want 1", imem_we); end
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_we !== 1'b0 || imem_wdata !== 32'h0 || imem_addr !== 8'd0 || req_ready !== 1'b0 || count !== 9'd0) begin
      errors++; $display("FAIL rstmid_async got we=%b %h@%0d rdy=%b cnt=%0d want all 0", imem_we, imem_wdata, imem_addr, req_ready, count); end
    $display("rstmid: we=%b wdata=%h addr=%0d", imem_we, imem_wdata, imem_addr);
    tick();
    rst = 1'b0;
    imem_ready = 1'b1;
    pulse_start();
    set_req(4'd0, 5'd1, 5'd2, 5'd7, 16'h0, 26'h0);
    tick();
    req_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00223820) begin
      errors++; $display("FAIL rstmid_restart got we=%b %h@%0d want 1 00223820@0", imem_we, imem_wdata, imem_addr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    finish = 1'b0;
    req_valid = 1'b0;
    req_kind = 4'd0;
    req_rs = '0;
    req_rt = '0;
    req_rd = '0;
    req_imm = '0;
    req_target = '0;
    imem_ready = 1'b1;
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_add();
    test_back_to_back();
    test_stall();
    test_full();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
